// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among NUM_REQ byte-stream requesters using a
// round-robin pick. A granted byte is handed to the transmitter with a
// one-cycle Tx_DV_out pulse. The arbiter then waits for Tx_Done_in, inserts an
// optional idle gap, and returns to IDLE for the next decision. A timeout
// guard drops the frame if Tx_Done_in never arrives.
//
// Ports
//   CLK            system clock, all state on the rising edge
//   RST_N          asynchronous active-low reset
//   req_valid_in   per-requester "byte pending", held until its ready pulse
//   req_data_in    requester k byte on bits [8k+7:8k]
//   req_ready_out  one-hot single-cycle pulse: requester k's byte was taken
//   Tx_DV_out      single-cycle start pulse to the transmitter
//   Tx_Byte_out    byte to the transmitter, stable until the next grant
//   Tx_Active_in   transmitter busy
//   Tx_Done_in     transmitter frame-complete pulse
//   grant_id_out   index of the current / last granted requester
//   busy_out       high whenever the arbiter is not in IDLE
//   timeout_out    single-cycle pulse when a frame is abandoned on timeout
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NUM_REQ-1:0]     req_valid_in,
    input  logic [8*NUM_REQ-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]     req_ready_out,
    output logic                   Tx_DV_out,
    output logic [7:0]             Tx_Byte_out,
    input  logic                   Tx_Active_in,
    input  logic                   Tx_Done_in,
    output logic [IDW-1:0]         grant_id_out,
    output logic                   busy_out,
    output logic                   timeout_out
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t         r_state;
    logic           r_prev_idle;
    logic [IDW-1:0] r_last;
    logic [TW-1:0]  r_tcnt;
    logic [GW-1:0]  r_gcnt;

    logic           w_line_idle;
    logic           w_tx_free;
    logic           w_found;
    logic [IDW-1:0] w_pick;
    logic [TW-1:0]  w_tcnt_inc;
    logic [7:0]     w_req_byte [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_byte
            assign w_req_byte[gi] = req_data_in[8*gi +: 8];
        end
    endgenerate

    // The line must have been quiet for two consecutive cycles. After a reset
    // in mid-frame this keeps us from launching until the old frame is gone.
    assign w_line_idle = !Tx_Active_in && !Tx_Done_in;
    assign w_tx_free   = w_line_idle && r_prev_idle;

    // Saturating increment so the counter can never wrap back into range.
    assign w_tcnt_inc = (r_tcnt == T_SAT) ? r_tcnt : r_tcnt + 1'b1;

    // Round-robin search starting at last+1. Walking the offsets from the far
    // end down lets the nearest valid requester overwrite any later one.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        for (int j = NUM_REQ; j >= 1; j--) begin
            if (req_valid_in[IDW'((int'(r_last) + j) % NUM_REQ)]) begin
                w_pick  = IDW'((int'(r_last) + j) % NUM_REQ);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_prev_idle   <= 1'b0;
            r_last        <= IDW'(NUM_REQ - 1);
            r_tcnt        <= '0;
            r_gcnt        <= '0;
            req_ready_out <= '0;
            Tx_DV_out     <= 1'b0;
            Tx_Byte_out   <= '0;
            grant_id_out  <= '0;
            busy_out      <= 1'b0;
            timeout_out   <= 1'b0;
        end else begin
            r_prev_idle   <= w_line_idle;
            Tx_DV_out     <= 1'b0;
            req_ready_out <= '0;
            timeout_out   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_tx_free && w_found) begin
                        Tx_Byte_out   <= w_req_byte[w_pick];
                        grant_id_out  <= w_pick;
                        r_last        <= w_pick;
                        Tx_DV_out     <= 1'b1;
                        req_ready_out <= NUM_REQ'(1) << w_pick;
                        busy_out      <= 1'b1;
                        r_state       <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    r_tcnt <= w_tcnt_inc;
                    // Done takes priority over a timeout expiring in the same cycle.
                    if (Tx_Done_in) begin
                        if (GAP_CYCLES > 0) begin
                            r_gcnt  <= '0;
                            r_state <= S_GAP;
                        end else begin
                            busy_out <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end else if (w_tcnt_inc == T_LAST) begin
                        // The byte is dropped; the requester already got its ready.
                        timeout_out <= 1'b1;
                        busy_out    <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                S_GAP: begin
                    if (r_gcnt == G_LAST) begin
                        busy_out <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end

                default: begin
                    busy_out <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for uart_tx_arbiter. Instance u0 runs with GAP_CYCLES=0, instance u1
// with GAP_CYCLES=5. Each has its own transmitter model (CLKS_PER_BIT=4).
// Transmitter 0 can be turned into a stub that never answers.
// A timeline model predicts every output on every cycle; directed scenarios
// add hand-computed expectations on grant order, spacing and data.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int TO    = 64;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req_valid [2];
    logic [31:0] req_data  [2];
    logic [3:0]  req_ready [2];
    logic        tx_dv     [2];
    logic [7:0]  tx_byte   [2];
    logic        tx_busy   [2] = '{1'b0, 1'b0};
    logic        tx_done   [2] = '{1'b0, 1'b0};
    logic [1:0]  gid       [2];
    logic        busy      [2];
    logic        to        [2];
    logic        stub      [2];

    uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) u0 (
        .CLK(clk), .RST_N(rst_n),
        .req_valid_in(req_valid[0]), .req_data_in(req_data[0]), .req_ready_out(req_ready[0]),
        .Tx_DV_out(tx_dv[0]), .Tx_Byte_out(tx_byte[0]),
        .Tx_Active_in(tx_busy[0]), .Tx_Done_in(tx_done[0]),
        .grant_id_out(gid[0]), .busy_out(busy[0]), .timeout_out(to[0])
    );

    uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(5), .TIMEOUT_CYCLES(TO)) u1 (
        .CLK(clk), .RST_N(rst_n),
        .req_valid_in(req_valid[1]), .req_data_in(req_data[1]), .req_ready_out(req_ready[1]),
        .Tx_DV_out(tx_dv[1]), .Tx_Byte_out(tx_byte[1]),
        .Tx_Active_in(tx_busy[1]), .Tx_Done_in(tx_done[1]),
        .grant_id_out(gid[1]), .busy_out(busy[1]), .timeout_out(to[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- transmitter models (never reset) ----------------
    int         tx_tick [2] = '{0, 0};
    logic [7:0] rx_sh   [2];
    logic [7:0] rx_q0   [$];
    int         frame_err = 0;

    // Serial line built from the live Tx_Byte_out, so a byte that changes
    // mid-frame shows up in the received data.
    function automatic logic ser(input int i);
        int b;
        b = tx_tick[i] / CPB;
        if (!tx_busy[i]) return 1'b1;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return tx_byte[i][b-1];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            tx_done[i] <= 1'b0;
            if (!tx_busy[i]) begin
                if (tx_dv[i] && !stub[i]) begin
                    tx_busy[i] <= 1'b1;
                    tx_tick[i] <= 0;
                end
            end else begin
                if (tx_tick[i] % CPB == CPB / 2) begin
                    if (tx_tick[i] / CPB >= 1 && tx_tick[i] / CPB <= 8)
                        rx_sh[i][tx_tick[i] / CPB - 1] <= ser(i);
                    else if ((tx_tick[i] / CPB == 0 && ser(i) !== 1'b0) ||
                             (tx_tick[i] / CPB == 9 && ser(i) !== 1'b1))
                        frame_err <= frame_err + 1;
                end
                if (tx_tick[i] == FRAME - 1) begin
                    tx_busy[i] <= 1'b0;
                    tx_done[i] <= 1'b1;
                    if (i == 0) rx_q0.push_back(rx_sh[0]);
                end
                tx_tick[i] <= tx_tick[i] + 1;
            end
        end
    end

    // ---------------- requesters ----------------
    logic [7:0] rq    [2][4][$];
    logic [3:0] man_v [2];
    logic [7:0] man_d;

    task automatic drive();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) begin
                req_valid[i][k]        = (rq[i][k].size() > 0) || man_v[i][k];
                req_data[i][8*k +: 8]  = (rq[i][k].size() > 0) ? rq[i][k][0] : man_d;
            end
    endtask

    // One clock: note ready pulses, then update valid/data just after the edge.
    task automatic step();
        logic [3:0] r [2];
        @(negedge clk);
        r[0] = req_ready[0];
        r[1] = req_ready[1];
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                if (r[i][k] && rq[i][k].size() > 0) void'(rq[i][k].pop_front());
        drive();
    endtask

    // ---------------- timeline model + per-cycle compare ----------------
    int         cyc = 0;
    int         m_last [2], m_dv_at [2], m_idle_from [2];
    logic       m_inframe [2], m_prev_idle [2];
    logic [7:0] m_byte [2];
    logic [1:0] m_gid  [2];
    logic       exp_dv [2], exp_busy [2], exp_to [2], prev_busy [2];
    logic [3:0] exp_rdy [2];
    int         dv_c [2][$], gid_l [2][$], done_c [2][$], to_c [2][$], fall_c [2][$];
    int         rdy3_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                check($sformatf("u%0d_rst_dv", i),    32'(tx_dv[i]),     32'd0);
                check($sformatf("u%0d_rst_ready", i), 32'(req_ready[i]), 32'd0);
                check($sformatf("u%0d_rst_byte", i),  32'(tx_byte[i]),   32'd0);
                check($sformatf("u%0d_rst_grant", i), 32'(gid[i]),       32'd0);
                check($sformatf("u%0d_rst_busy", i),  32'(busy[i]),      32'd0);
                check($sformatf("u%0d_rst_to", i),    32'(to[i]),        32'd0);
                m_last[i] = NR - 1; m_inframe[i] = 1'b0; m_prev_idle[i] = 1'b0;
                m_idle_from[i] = 0; m_dv_at[i] = 0; m_byte[i] = 8'h00; m_gid[i] = 2'd0;
                exp_dv[i] = 1'b0; exp_rdy[i] = 4'h0; exp_busy[i] = 1'b0; exp_to[i] = 1'b0;
            end else begin
                logic cur_idle, free, found;
                int   k;
                check($sformatf("u%0d_dv", i),      32'(tx_dv[i]),     32'(exp_dv[i]));
                check($sformatf("u%0d_ready", i),   32'(req_ready[i]), 32'(exp_rdy[i]));
                check($sformatf("u%0d_byte", i),    32'(tx_byte[i]),   32'(m_byte[i]));
                check($sformatf("u%0d_grant", i),   32'(gid[i]),       32'(m_gid[i]));
                check($sformatf("u%0d_busy", i),    32'(busy[i]),      32'(exp_busy[i]));
                check($sformatf("u%0d_timeout", i), 32'(to[i]),        32'(exp_to[i]));

                if (tx_dv[i]) begin
                    dv_c[i].push_back(cyc);
                    gid_l[i].push_back(int'(gid[i]));
                    $display("u%0d cycle %0d: grant %0d byte %02h", i, cyc, gid[i], tx_byte[i]);
                end
                if (to[i]) begin
                    to_c[i].push_back(cyc);
                    $display("u%0d cycle %0d: timeout", i, cyc);
                end
                if (tx_done[i]) done_c[i].push_back(cyc);
                if (prev_busy[i] && !busy[i]) fall_c[i].push_back(cyc);
                if (req_ready[i][3]) rdy3_cnt[i]++;

                // Predict the next cycle from this cycle's inputs.
                cur_idle = !tx_busy[i] && !tx_done[i];
                free     = cur_idle && m_prev_idle[i];
                m_prev_idle[i] = cur_idle;
                exp_dv[i] = 1'b0; exp_rdy[i] = 4'h0; exp_to[i] = 1'b0;
                if (m_inframe[i]) begin
                    if (cyc > m_dv_at[i]) begin
                        if (tx_done[i]) begin
                            m_inframe[i]   = 1'b0;
                            m_idle_from[i] = cyc + 1 + ((i == 0) ? 0 : 5);
                        end else if (cyc - m_dv_at[i] == TO - 1) begin
                            m_inframe[i]   = 1'b0;
                            m_idle_from[i] = cyc + 1;
                            exp_to[i]      = 1'b1;
                        end
                    end
                end else if (cyc >= m_idle_from[i] && free) begin
                    found = 1'b0;
                    k = 0;
                    for (int j = 1; j <= NR; j++)
                        if (!found && req_valid[i][(m_last[i] + j) % NR]) begin
                            found = 1'b1;
                            k = (m_last[i] + j) % NR;
                        end
                    if (found) begin
                        m_last[i]    = k;
                        m_byte[i]    = req_data[i][8*k +: 8];
                        m_gid[i]     = 2'(k);
                        exp_dv[i]    = 1'b1;
                        exp_rdy[i]   = 4'(1 << k);
                        m_inframe[i] = 1'b1;
                        m_dv_at[i]   = cyc + 1;
                    end
                end
                exp_busy[i] = m_inframe[i] || (cyc + 1 < m_idle_from[i]);
            end
            prev_busy[i] = busy[i];
        end
        cyc++;
    end

    // ---------------- directed scenarios ----------------
    initial begin
        stub[0] = 1'b0; stub[1] = 1'b0;
        man_v[0] = 4'h0; man_v[1] = 4'h0; man_d = 8'h00;
        drive();
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Round-robin on u0, gap spacing on u1.
        for (int k = 0; k < 4; k++) begin
            rq[0][k].push_back(8'h10 + 8'(k));
            rq[0][k].push_back(8'h10 + 8'(k));
        end
        rq[1][0].push_back(8'h20); rq[1][0].push_back(8'h21);
        rq[1][1].push_back(8'h30); rq[1][1].push_back(8'h31);
        drive();
        for (int n = 0; n < 3000 && !(rx_q0.size() >= 8 && done_c[1].size() >= 4); n++) step();
        check("wait_rr", 32'(rx_q0.size() >= 8 && done_c[1].size() >= 4), 32'd1);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("rr_grant%0d", j), 32'(gid_l[0][j]), 32'(j % 4));
            check($sformatf("rr_byte%0d", j),  32'(rx_q0[j]),    32'(8'h10 + 8'(j % 4)));
        end
        for (int j = 1; j < 8; j++)
            check($sformatf("rr_spacing%0d", j), 32'(dv_c[0][j] - done_c[0][j-1]), 32'd3);
        for (int j = 1; j < 4; j++) begin
            check($sformatf("gap_spacing%0d", j), 32'(dv_c[1][j] - done_c[1][j-1]), 32'd7);
            check($sformatf("gap_grant%0d", j),   32'(gid_l[1][j]), 32'(j % 2));
        end

        // Single request on requester 2.
        rq[0][2].push_back(8'hA5);
        drive();
        for (int n = 0; n < 500 && !(fall_c[0].size() >= 9 && done_c[0].size() >= 9); n++) step();
        check("wait_single", 32'(fall_c[0].size() >= 9 && done_c[0].size() >= 9), 32'd1);
        check("single_grant", 32'(gid_l[0][8]), 32'd2);
        check("single_serial", 32'(rx_q0[8]), 32'hA5);
        check("single_dv_count", 32'(dv_c[0].size()), 32'd9);
        check("single_busy_fall", 32'(fall_c[0][8] - done_c[0][8]), 32'd1);

        // Requester 3 flashes valid for one cycle while a frame is in flight.
        rq[0][0].push_back(8'h77);
        drive();
        for (int n = 0; n < 100 && dv_c[0].size() < 10; n++) step();
        repeat (5) step();
        man_v[0][3] = 1'b1; man_d = 8'hEE; drive();
        step();
        man_v[0][3] = 1'b0; drive();
        for (int n = 0; n < 500 && rx_q0.size() < 10; n++) step();
        repeat (10) step();
        check("withdraw_rdy3", 32'(rdy3_cnt[0]), 32'd2);
        check("withdraw_byte", 32'(rx_q0[9]), 32'h77);
        check("withdraw_dv_count", 32'(dv_c[0].size()), 32'd10);

        // Timeout with a transmitter that never answers.
        stub[0] = 1'b1;
        rq[0][0].push_back(8'h3C);
        drive();
        for (int n = 0; n < 100 && dv_c[0].size() < 11; n++) step();
        rq[0][1].push_back(8'h3D);
        drive();
        for (int n = 0; n < 500 && to_c[0].size() < 2; n++) step();
        check("wait_timeout", 32'(to_c[0].size()), 32'd2);
        check("to_grant0", 32'(gid_l[0][10]), 32'd0);
        check("to_delay", 32'(to_c[0][0] - dv_c[0][10]), 32'd64);
        check("to_next_grant", 32'(gid_l[0][11]), 32'd1);
        check("to_next_dv", 32'(dv_c[0][11] - to_c[0][0]), 32'd1);
        stub[0] = 1'b0;
        repeat (5) step();

        // Reset during the data bits of 0x55.
        rq[0][0].push_back(8'h55);
        drive();
        for (int n = 0; n < 100 && dv_c[0].size() < 13; n++) step();
        repeat (15) step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        rq[0][0].push_back(8'h5A);
        drive();
        for (int n = 0; n < 500 && rx_q0.size() < 12; n++) step();
        repeat (3) step();
        check("wait_reset", 32'(rx_q0.size()), 32'd12);
        check("reset_relaunch", 32'(dv_c[0][13] - done_c[0][10]), 32'd3);
        check("reset_grant", 32'(gid_l[0][13]), 32'd0);
        check("reset_byte", 32'(rx_q0[11]), 32'h5A);
        check("framing", 32'(frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
